// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: sequences start/data/parity/stop checks against an external edge/bit counter.
// Optional macro UART_RX_ERR_FLAGS_EN adds per-frame par_err_flag/stp_err_flag outputs.
module uart_rx_fsm #(
    parameter int EDGE_W = 3,
    parameter int BIT_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic              par_en,
    input  logic [EDGE_W-1:0] edge_cnt,
    input  logic [BIT_W-1:0]  bit_cnt,
    input  logic              strt_glitch,
    input  logic              par_err,
    input  logic              stp_err,
    output logic              cnt_enable,
    output logic              dat_samp_en,
    output logic              deser_en,
    output logic              strt_chk_en,
    output logic              par_chk_en,
    output logic              stp_chk_en,
    output logic              data_valid
`ifdef UART_RX_ERR_FLAGS_EN
    ,
    output logic              par_err_flag,
    output logic              stp_err_flag
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        CHECK  = 3'd5
    } state_t;

    localparam logic [EDGE_W-1:0] MID       = EDGE_W'(2 ** (EDGE_W - 1));
    localparam logic [EDGE_W-1:0] CHK       = MID + EDGE_W'(2);
    localparam logic [EDGE_W-1:0] LAST      = '1;
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W);

    state_t            state_q, state_d;
    logic              par_en_q, par_en_d;
    logic              err_q, err_d;
    logic              cnt_enable_q, cnt_enable_d;
    logic              dat_samp_en_q, dat_samp_en_d;
    logic              deser_en_q, deser_en_d;
    logic              strt_chk_en_q, strt_chk_en_d;
    logic              par_chk_en_q, par_chk_en_d;
    logic              stp_chk_en_q, stp_chk_en_d;
    logic              data_valid_q, data_valid_d;
    logic [EDGE_W-1:0] edge_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            par_en_q      <= 1'b0;
            err_q         <= 1'b0;
            cnt_enable_q  <= 1'b0;
            dat_samp_en_q <= 1'b0;
            deser_en_q    <= 1'b0;
            strt_chk_en_q <= 1'b0;
            par_chk_en_q  <= 1'b0;
            stp_chk_en_q  <= 1'b0;
            data_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            par_en_q      <= par_en_d;
            err_q         <= err_d;
            cnt_enable_q  <= cnt_enable_d;
            dat_samp_en_q <= dat_samp_en_d;
            deser_en_q    <= deser_en_d;
            strt_chk_en_q <= strt_chk_en_d;
            par_chk_en_q  <= par_chk_en_d;
            stp_chk_en_q  <= stp_chk_en_d;
            data_valid_q  <= data_valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        par_en_d = par_en_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (!rx_in) begin
                    state_d  = START;
                    par_en_d = par_en;
                end
            end
            START: begin
                if (edge_cnt == LAST) state_d = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                if (edge_cnt == LAST && bit_cnt == DATA_LAST) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (edge_cnt == LAST) begin
                    err_d   = err_q | par_err;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (edge_cnt == LAST) begin
                    err_d   = err_q | stp_err;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                err_d = 1'b0;
                if (!rx_in) begin
                    state_d  = START;
                    par_en_d = par_en;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
        endcase

        // Strobes are registered, so they are decoded from the counter value the next cycle will show.
        edge_nx       = cnt_enable_q ? edge_cnt + EDGE_W'(1) : '0;
        cnt_enable_d  = state_d inside {START, DATA, PARITY, STOP};
        dat_samp_en_d = state_d inside {START, DATA};
        strt_chk_en_d = (state_d == START)  && (edge_nx == CHK);
        deser_en_d    = (state_d == DATA)   && (edge_nx == CHK);
        par_chk_en_d  = (state_d == PARITY) && (edge_nx == CHK);
        stp_chk_en_d  = (state_d == STOP)   && (edge_nx == CHK);
        data_valid_d  = (state_d == CHECK)  && !err_d;
    end

    assign cnt_enable  = cnt_enable_q;
    assign dat_samp_en = dat_samp_en_q;
    assign deser_en    = deser_en_q;
    assign strt_chk_en = strt_chk_en_q;
    assign par_chk_en  = par_chk_en_q;
    assign stp_chk_en  = stp_chk_en_q;
    assign data_valid  = data_valid_q;

`ifdef UART_RX_ERR_FLAGS_EN
    logic perr_q, perr_d;
    logic par_flag_q, par_flag_d;
    logic stp_flag_q, stp_flag_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q     <= 1'b0;
            par_flag_q <= 1'b0;
            stp_flag_q <= 1'b0;
        end else begin
            perr_q     <= perr_d;
            par_flag_q <= par_flag_d;
            stp_flag_q <= stp_flag_d;
        end
    end

    // Parity error is remembered separately from err_q so each flag reports its own cause.
    always_comb begin
        perr_d     = perr_q;
        par_flag_d = 1'b0;
        stp_flag_d = 1'b0;
        if (!(state_q inside {START, DATA, PARITY, STOP})) perr_d = 1'b0;
        if (state_q == PARITY && edge_cnt == LAST) perr_d = perr_q | par_err;
        if (state_q == STOP && edge_cnt == LAST) begin
            par_flag_d = perr_q;
            stp_flag_d = stp_err;
        end
    end

    assign par_err_flag = par_flag_q;
    assign stp_err_flag = stp_flag_q;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with a behavioural edge/bit counter; checker results are driven as stimulus.
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       par_en = 1'b0;
    logic       strt_glitch = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic [2:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       cnt_enable, dat_samp_en, deser_en, strt_chk_en;
    logic       par_chk_en, stp_chk_en, data_valid;
`ifdef UART_RX_ERR_FLAGS_EN
    logic       par_err_flag, stp_err_flag;
`endif

    uart_rx_fsm #(.EDGE_W(3), .BIT_W(4), .DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .par_en      (par_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .cnt_enable  (cnt_enable),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid)
`ifdef UART_RX_ERR_FLAGS_EN
        ,
        .par_err_flag(par_err_flag),
        .stp_err_flag(stp_err_flag)
`endif
    );

    always #5 clk = ~clk;

    // Edge/bit counter: clears while disabled, edge wraps every 8 ticks into the bit index.
    always @(posedge clk or negedge rst) begin
        if (!rst || !cnt_enable) begin
            edge_cnt <= 3'd0;
            bit_cnt  <= 4'd0;
        end else begin
            edge_cnt <= edge_cnt + 3'd1;
            if (edge_cnt == 3'd7) bit_cnt <= bit_cnt + 4'd1;
        end
    end

    int         cyc = 0, dv_cyc = 0, dv_gap = 0;
    int         n_deser = 0, n_deser_bad = 0, n_strt = 0, n_par = 0, n_stp = 0;
    int         n_dv = 0, n_dv_long = 0, n_cnt = 0, n_excl = 0, n_pflag = 0, n_sflag = 0;
    logic [7:0] par_pos = 8'h00, stp_pos = 8'h00, strt_pos = 8'h00, dv_prev_pos = 8'h00;
    logic [7:0] prev_pos = 8'h00;
    logic       prev_dv = 1'b0;

    // Position is packed as {bit_cnt, 0, edge_cnt} so 8'h96 reads as bit 9, edge 6.
    always @(negedge clk) begin
        cyc      <= cyc + 1;
        prev_dv  <= data_valid;
        prev_pos <= {bit_cnt, 1'b0, edge_cnt};
        if (rst) begin
            if (cnt_enable) n_cnt <= n_cnt + 1;
            if (deser_en) begin
                n_deser <= n_deser + 1;
                if (edge_cnt != 3'd6) n_deser_bad <= n_deser_bad + 1;
            end
            if (strt_chk_en) begin n_strt <= n_strt + 1; strt_pos <= {bit_cnt, 1'b0, edge_cnt}; end
            if (par_chk_en)  begin n_par  <= n_par + 1;  par_pos  <= {bit_cnt, 1'b0, edge_cnt}; end
            if (stp_chk_en)  begin n_stp  <= n_stp + 1;  stp_pos  <= {bit_cnt, 1'b0, edge_cnt}; end
            if ($countones({deser_en, strt_chk_en, par_chk_en, stp_chk_en}) > 1) n_excl <= n_excl + 1;
            if (data_valid) begin
                n_dv <= n_dv + 1;
                if (prev_dv) n_dv_long <= n_dv_long + 1;
                else begin
                    dv_prev_pos <= prev_pos;
                    dv_gap      <= cyc - dv_cyc;
                    dv_cyc      <= cyc;
                end
            end
`ifdef UART_RX_ERR_FLAGS_EN
            if (par_err_flag) n_pflag <= n_pflag + 1;
            if (stp_err_flag) n_sflag <= n_sflag + 1;
`endif
        end
    end

    int n_cmp = 0, n_mis = 0;
    int b_deser, b_strt, b_par, b_stp, b_dv, b_dv_long, b_cnt, b_pflag, b_sflag;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_deser = n_deser; b_strt = n_strt; b_par = n_par; b_stp = n_stp;
        b_dv = n_dv; b_dv_long = n_dv_long; b_cnt = n_cnt; b_pflag = n_pflag; b_sflag = n_sflag;
    endtask

    function automatic logic [6:0] outs();
        return {cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid};
    endfunction

    task automatic drive_body(input logic [7:0] d, input logic pe);
        rx_in = 1'b0;
        repeat (8) @(negedge clk);
        par_en = ~pe;
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            repeat (8) @(negedge clk);
        end
        if (pe) begin
            rx_in = ^d;
            repeat (8) @(negedge clk);
        end
        rx_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic perr, input logic serr);
        par_en  = pe;
        par_err = perr;
        stp_err = serr;
        drive_body(d, pe);
        repeat (16) @(negedge clk);
        par_err = 1'b0;
        stp_err = 1'b0;
        par_en  = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outs", {25'd0, outs()}, 32'd0);
        rst = 1'b1;
        snap();
        repeat (10) @(negedge clk);
        check_val("idle_no_cnt", n_cnt - b_cnt, 0);

        // 8N1, 0xA5
        snap();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        check_val("n81_deser_cnt", n_deser - b_deser, 8);
        check_val("n81_deser_edge", n_deser_bad, 0);
        check_val("n81_strt_pos", strt_pos, 8'h06);
        check_val("n81_par_cnt", n_par - b_par, 0);
        check_val("n81_stp_pos", stp_pos, 8'h96);
        check_val("n81_dv_cnt", n_dv - b_dv, 1);
        check_val("n81_dv_after", dv_prev_pos, 8'h97);
        check_val("n81_cnt_cycles", n_cnt - b_cnt, 80);
        check_val("n81_idle", cnt_enable, 1'b0);

        // 8E1, 0x3C
        snap();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check_val("e81_par_cnt", n_par - b_par, 1);
        check_val("e81_par_pos", par_pos, 8'h96);
        check_val("e81_stp_pos", stp_pos, 8'hA6);
        check_val("e81_deser_cnt", n_deser - b_deser, 8);
        check_val("e81_dv_cnt", n_dv - b_dv, 1);
        check_val("e81_dv_after", dv_prev_pos, 8'hA7);
        check_val("e81_cnt_cycles", n_cnt - b_cnt, 88);

        // start glitch
        snap();
        strt_glitch = 1'b1;
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (14) @(negedge clk);
        strt_glitch = 1'b0;
        check_val("glitch_cnt_cycles", n_cnt - b_cnt, 8);
        check_val("glitch_strt_cnt", n_strt - b_strt, 1);
        check_val("glitch_deser_cnt", n_deser - b_deser, 0);
        check_val("glitch_dv_cnt", n_dv - b_dv, 0);
        check_val("glitch_idle", cnt_enable, 1'b0);

        // parity error, then a clean frame
        snap();
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        check_val("perr_dv_cnt", n_dv - b_dv, 0);
`ifdef UART_RX_ERR_FLAGS_EN
        check_val("perr_pflag", n_pflag - b_pflag, 1);
        check_val("perr_sflag", n_sflag - b_sflag, 0);
`endif
        snap();
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        check_val("after_perr_dv", n_dv - b_dv, 1);

        // stop error
        snap();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        check_val("serr_dv_cnt", n_dv - b_dv, 0);
`ifdef UART_RX_ERR_FLAGS_EN
        check_val("serr_sflag", n_sflag - b_sflag, 1);
        check_val("serr_pflag", n_pflag - b_pflag, 0);
`endif

        // back-to-back 8N1 frames
        snap();
        par_en = 1'b0;
        drive_body(8'hA5, 1'b0);
        par_en = 1'b0;
        for (int i = 0; i < 30 && !data_valid; i++) @(negedge clk);
        check_val("b2b_dv_seen", data_valid, 1'b1);
        drive_body(8'h0F, 1'b0);
        par_en = 1'b0;
        repeat (16) @(negedge clk);
        check_val("b2b_dv_cnt", n_dv - b_dv, 2);
        check_val("b2b_dv_single", n_dv_long - b_dv_long, 0);
        check_val("b2b_dv_gap", dv_gap, 81);
        check_val("b2b_cnt_cycles", n_cnt - b_cnt, 160);

        // reset during DATA at bit 4
        rx_in = 1'b0;
        repeat (8) @(negedge clk);
        rx_in = 1'b1;
        for (int i = 0; i < 100 && bit_cnt != 4'd4; i++) @(negedge clk);
        check_val("rst_reach_bit4", bit_cnt, 4'd4);
        check_val("rst_pre_cnt_en", cnt_enable, 1'b1);
        #2 rst = 1'b0;
        #1 check_val("rst_async_outs", {25'd0, outs()}, 32'd0);
        repeat (3) @(negedge clk);
        check_val("rst_held_outs", {25'd0, outs()}, 32'd0);
        rx_in = 1'b1;
        rst = 1'b1;
        snap();
        repeat (30) @(negedge clk);
        check_val("rst_post_strobes",
                  (n_cnt - b_cnt) + (n_deser - b_deser) + (n_strt - b_strt) +
                  (n_par - b_par) + (n_stp - b_stp) + (n_dv - b_dv), 0);

        check_val("strobe_exclusive", n_excl, 0);
        check_val("deser_edge_all", n_deser_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
